t_ff_counter: RTL

- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit bank of T flip-flops.
- Runtime mode select: independent per-bit toggle, synchronous binary up-count, binary down-count, or hold.
- Features: synchronous parallel load, wrap or saturate at the count boundaries, and registered status pulses.
- Used as a general event counter / toggle register in the lab designs.

---
 rtl/t_ff_pkg.sv | 12 +
 rtl/t_ff_cell.sv | 18 +
 rtl/t_ff_counter.sv | 78 +++++++
 3 files changed

// File: rtl/t_ff_pkg.sv
// Shared mode encoding for the T flip-flop counter bank.
// Imported by the counter top and its bench.
package t_ff_pkg;

  typedef logic [1:0] t_ff_mode_t;

  localparam t_ff_mode_t MODE_TOGGLE = 2'b00;
  localparam t_ff_mode_t MODE_UP     = 2'b01;
  localparam t_ff_mode_t MODE_DOWN   = 2'b10;
  localparam t_ff_mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop with synchronous parallel load.
// Async active-high reset clears the bit.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic d,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= 1'b0;
    else if (load) q <= d;
    else           q <= q ^ t;
  end

endmodule

// File: rtl/t_ff_counter.sv
// WIDTH-bit T flip-flop bank: toggle, up/down count or hold,
// with parallel load, wrap/saturate and registered status pulses.
module t_ff_counter
  import t_ff_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  t_ff_mode_t       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam bit SAT = (SATURATE != 0);

  // cup[i]/cdn[i]: all lower bits one/zero; top entry flags the boundary
  logic [WIDTH:0]   cup;
  logic [WIDTH:0]   cdn;
  logic [WIDTH-1:0] tv;
  logic [WIDTH-1:0] tq;
  logic             bnd_up;
  logic             bnd_dn;
  logic             bnd;

  assign cup[0] = 1'b1;
  assign cdn[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign cup[i+1] = cup[i] & q[i];
    assign cdn[i+1] = cdn[i] & ~q[i];

    t_ff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .d    (d[i]),
      .t    (tq[i]),
      .q    (q[i])
    );
  end

  assign bnd_up = en & (mode == MODE_UP) & cup[WIDTH];
  assign bnd_dn = en & (mode == MODE_DOWN) & cdn[WIDTH];
  assign bnd    = ~load & (bnd_up | bnd_dn);
  assign tc     = ~load & (bnd_up | bnd_dn);

  always_comb begin
    tv = '0;
    unique case (1'b1)
      (mode == MODE_TOGGLE): tv = t;
      (mode == MODE_UP):     tv = cup[WIDTH-1:0];
      (mode == MODE_DOWN):   tv = cdn[WIDTH-1:0];
      (mode == MODE_HOLD):   tv = '0;
    endcase
  end

  // saturation masks every toggle so q holds at the boundary
  assign tq = (en && !(SAT && bnd)) ? tv : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else begin
      wrap <= bnd & ~SAT;
      sat  <= bnd & SAT;
    end
  end

endmodule
